// File: rtl/pio_poll_pkg.sv
// ----------------------------------------------------------------------------
// pio_poll_pkg
// Shared definitions for the PIO polling initiator:
//   - poll_state_t     : Avalon read FSM states
//   - MAX_READ_LATENCY : largest supported slave read latency
//   - LAT_CNT_W        : width of the read-latency counter
//   - clamp_latency()  : folds an out-of-range latency parameter into 1..MAX
// ----------------------------------------------------------------------------
package pio_poll_pkg;

    typedef enum logic [1:0] {
        IDLE,   // waiting out the poll interval
        REQ,    // read strobe asserted, waiting for waitrequest to drop
        WAIT,   // read accepted, waiting for readdata
        CMP     // compare captured sample with the last reported one
    } poll_state_t;

    localparam int MAX_READ_LATENCY = 4;
    localparam int LAT_CNT_W        = $clog2(MAX_READ_LATENCY + 1);

    // Keeps the latency counter compare inside its range even if the
    // instantiating code passes a nonsensical latency.
    function automatic int clamp_latency(input int lat);
        if (lat < 1) begin
            return 1;
        end
        if (lat > MAX_READ_LATENCY) begin
            return MAX_READ_LATENCY;
        end
        return lat;
    endfunction

endpackage

// File: rtl/poll_timer.sv
// ----------------------------------------------------------------------------
// poll_timer
// Enable-gated interval counter. While run=1 the counter advances once per
// clock; on the cycle it holds INTERVAL-1 the tick output is high and the
// counter returns to 0. Dropping run clears the counter, so every new run
// period starts a full interval from scratch.
//
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset, clears the counter
//   run   : count enable
//   tick  : high for one cycle when INTERVAL run cycles have elapsed
// ----------------------------------------------------------------------------
module poll_timer #(
    parameter int CNT_W    = 16,
    parameter int INTERVAL = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    // An interval below 1 degenerates to a tick on every run cycle.
    localparam int                 INTERVAL_EFF = (INTERVAL < 1) ? 1 : INTERVAL;
    localparam logic [CNT_W-1:0]   LAST         = CNT_W'(INTERVAL_EFF - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        tick    = run && (count_q == LAST);
        count_d = count_q + CNT_W'(1);
        if (!run || tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pio_poll_master.sv
// ----------------------------------------------------------------------------
// pio_poll_master
// Avalon-MM read initiator that periodically reads a PIO input register and
// forwards only changed values on a valid/ready stream.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   enable            : polling enable; an in-flight read always completes
//   avm_address       : constant POLL_ADDR
//   avm_read          : registered read strobe, held until waitrequest drops
//   avm_waitrequest   : slave stall
//   avm_readdata      : read data, valid READ_LATENCY cycles after acceptance
//   out_valid/ready   : stream handshake for changed samples
//   out_data          : most recent changed sample, stable while pending
//   overrun           : sticky, a pending sample was replaced before consumed
//   overrun_clr       : clears overrun (a same-cycle set takes priority)
//
// Poll period with no stall: POLL_INTERVAL (IDLE) + 1 (REQ) +
// READ_LATENCY (WAIT) + 1 (CMP) cycles.
// ----------------------------------------------------------------------------
module pio_poll_master
    import pio_poll_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 2,
    parameter int POLL_ADDR     = 0,
    parameter int READ_LATENCY  = 1,
    parameter int POLL_INTERVAL = 1000,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              overrun,
    input  logic              overrun_clr
);

    localparam int                   LAT_EFF  = clamp_latency(READ_LATENCY);
    localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(LAT_EFF);

    poll_state_t          state_q,     state_d;
    logic                 avm_read_q,  avm_read_d;
    logic [LAT_CNT_W-1:0] lat_q,       lat_d;
    logic [DATA_W-1:0]    sample_q,    sample_d;
    logic [DATA_W-1:0]    last_q,      last_d;
    logic                 first_q,     first_d;
    logic                 out_valid_q, out_valid_d;
    logic [DATA_W-1:0]    out_data_q,  out_data_d;
    logic                 overrun_q,   overrun_d;

    logic                 poll_tick;
    logic                 timer_run;
    logic                 sample_changed;
    logic                 overrun_set;

    // The interval only runs while idle, so it restarts from zero after
    // every completed poll and after any period with enable low.
    assign timer_run = enable && (state_q == IDLE);

    poll_timer #(
        .CNT_W    (CNT_W),
        .INTERVAL (POLL_INTERVAL)
    ) u_poll_timer (
        .clk   (clk),
        .reset (reset),
        .run   (timer_run),
        .tick  (poll_tick)
    );

    // The very first sample after reset is always reported.
    assign sample_changed = first_q || (sample_q != last_q);

    always_comb begin
        state_d     = state_q;
        avm_read_d  = avm_read_q;
        lat_d       = lat_q;
        sample_d    = sample_q;
        last_d      = last_q;
        first_d     = first_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        overrun_set = 1'b0;

        // A handshake consumes the pending sample; a CMP reporting a new
        // change below overrides this and keeps out_valid high.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (poll_tick) begin
                    state_d    = REQ;
                    avm_read_d = 1'b1;
                end
            end
            REQ: begin
                // Read stays asserted (address is constant) until accepted.
                if (!avm_waitrequest) begin
                    avm_read_d = 1'b0;
                    lat_d      = LAT_CNT_W'(1);
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                // lat_q holds the number of cycles since acceptance.
                if (lat_q == LAT_LAST) begin
                    sample_d = avm_readdata;
                    state_d  = CMP;
                end else begin
                    lat_d = lat_q + LAT_CNT_W'(1);
                end
            end
            CMP: begin
                state_d = IDLE;
                if (sample_changed) begin
                    last_d      = sample_q;
                    out_data_d  = sample_q;
                    out_valid_d = 1'b1;
                    first_d     = 1'b0;
                    // Replacing a sample that is not being taken this cycle
                    // loses it.
                    overrun_set = out_valid_q && !out_ready;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (overrun_set) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            avm_read_q  <= 1'b0;
            lat_q       <= '0;
            sample_q    <= '0;
            last_q      <= '0;
            first_q     <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            avm_read_q  <= avm_read_d;
            lat_q       <= lat_d;
            sample_q    <= sample_d;
            last_q      <= last_d;
            first_q     <= first_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            overrun_q   <= overrun_d;
        end
    end

    assign avm_address = ADDR_W'(POLL_ADDR);
    assign avm_read    = avm_read_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_pio_poll_master.sv
// ----------------------------------------------------------------------------
// tb_pio_poll_master
// Two instances (read latency 1 and 3, interval 8) share all stimulus. Each
// has a PIO slave model (returns the input value latched at acceptance,
// random junk on every other cycle) and a cycle reference model built from
// poll timing arithmetic. A directed sequence with literal expectations is
// followed by a randomized phase.
// ----------------------------------------------------------------------------
module tb_pio_poll_master;

    localparam int P = 8;

    typedef struct {
        bit          rd;
        bit          valid;
        bit          ovr;
        bit          first;
        logic [31:0] data;
        logic [31:0] last;
        logic [31:0] sample;
        int          idle;   // enabled idle cycles elapsed
        int          left;   // cycles until the compare completes
    } mstate_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        wr;
    logic        out_ready;
    logic        overrun_clr;
    logic [31:0] in_port;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_on   = 1'b0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock edge of the reference: timing by counting interval, latency
    // and compare cycles; stream rules applied on the compare cycle.
    function automatic mstate_t model_step(input mstate_t s, input int lat,
                                           input logic rst, input logic en,
                                           input logic w, input logic rdy,
                                           input logic clr, input logic [31:0] pin);
        mstate_t n;
        bit      cmp;
        bit      set;
        n   = s;
        cmp = 1'b0;
        set = 1'b0;
        if (rst) begin
            n.rd = 0; n.valid = 0; n.ovr = 0; n.first = 1;
            n.data = '0; n.last = '0; n.sample = '0; n.idle = 0; n.left = 0;
            return n;
        end
        if (s.rd) begin
            if (!w) begin
                n.rd     = 0;
                n.sample = pin;
                n.left   = lat + 1;
            end
        end else if (s.left > 0) begin
            n.left = s.left - 1;
            cmp    = (s.left == 1);
        end else if (en) begin
            if (s.idle == P - 1) begin
                n.idle = 0;
                n.rd   = 1;
            end else begin
                n.idle = s.idle + 1;
            end
        end else begin
            n.idle = 0;
        end
        if (cmp && (s.first || s.sample != s.last)) begin
            n.valid = 1;
            n.data  = s.sample;
            n.last  = s.sample;
            n.first = 0;
            set     = s.valid && !rdy;
        end else if (s.valid && rdy) begin
            n.valid = 0;
        end
        if (set) begin
            n.ovr = 1;
        end else if (clr) begin
            n.ovr = 0;
        end
        return n;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int LAT = (gi == 0) ? 1 : 3;

        logic        avm_read_w;
        logic [1:0]  addr_w;
        logic [31:0] rdata_w;
        logic        out_valid_w;
        logic [31:0] out_data_w;
        logic        overrun_w;
        logic        rd_seen;
        logic [31:0] junk;
        logic [31:0] dpipe [LAT];
        logic        vpipe [LAT];
        mstate_t     m;
        bit          prev_valid;
        logic [31:0] prev_data;

        pio_poll_master #(
            .DATA_W        (32),
            .ADDR_W        (2),
            .POLL_ADDR     (0),
            .READ_LATENCY  (LAT),
            .POLL_INTERVAL (P),
            .CNT_W         (16)
        ) u_dut (
            .clk             (clk),
            .reset           (reset),
            .enable          (enable),
            .avm_address     (addr_w),
            .avm_read        (avm_read_w),
            .avm_waitrequest (wr),
            .avm_readdata    (rdata_w),
            .out_valid       (out_valid_w),
            .out_ready       (out_ready),
            .out_data        (out_data_w),
            .overrun         (overrun_w),
            .overrun_clr     (overrun_clr)
        );

        // Slave: captures the input at acceptance, presents it LAT cycles
        // later, junk otherwise.
        always @(negedge clk) rd_seen <= avm_read_w;

        always @(posedge clk) begin
            junk     <= $urandom;
            vpipe[0] <= rd_seen && !wr;
            dpipe[0] <= in_port;
            for (int i = 1; i < LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
                dpipe[i] <= dpipe[i-1];
            end
        end

        assign rdata_w = vpipe[LAT-1] ? dpipe[LAT-1] : junk;

        always @(posedge clk) begin
            m <= model_step(m, LAT, reset, enable, wr, out_ready, overrun_clr, in_port);
        end

        always @(negedge clk) begin
            if (chk_on) begin
                chk($sformatf("L%0d_avm_read", LAT),    32'(avm_read_w),  32'(m.rd));
                chk($sformatf("L%0d_avm_address", LAT), 32'(addr_w),      32'd0);
                chk($sformatf("L%0d_out_valid", LAT),   32'(out_valid_w), 32'(m.valid));
                chk($sformatf("L%0d_out_data", LAT),    out_data_w,       m.data);
                chk($sformatf("L%0d_overrun", LAT),     32'(overrun_w),   32'(m.ovr));
                if (m.valid && (!prev_valid || m.data != prev_data)) begin
                    $display("L%0d t=%0t new sample 0x%08h overrun=%0d", LAT, $time, m.data, m.ovr);
                end
            end
            prev_valid <= m.valid;
            prev_data  <= m.data;
        end
    end

    // Cycles until DUT0 shows avm_read, bounded.
    task automatic wait_read(output int n);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (g_dut[0].avm_read_w) begin
                return;
            end
        end
        $display("FAIL wait_read: no avm_read within 40 cycles");
    endtask

    int n;
    int hi;
    int v0;
    int v1;

    initial begin
        reset = 1; enable = 0; wr = 0; out_ready = 0; overrun_clr = 0; in_port = '0;
        repeat (4) @(negedge clk);
        chk_on = 1;
        chk("rst_read",  32'(g_dut[0].avm_read_w),  32'd0);
        chk("rst_valid", 32'(g_dut[0].out_valid_w), 32'd0);
        chk("rst_data",  g_dut[0].out_data_w,       32'd0);
        chk("rst_ovr",   32'(g_dut[0].overrun_w),   32'd0);

        // First poll and first sample.
        reset = 0; enable = 1;
        wait_read(n);
        chk("first_poll_delay", n, 8);
        v0 = 0; v1 = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (v0 == 0 && g_dut[0].out_valid_w) v0 = k;
            if (v1 == 0 && g_dut[1].out_valid_w) v1 = k;
        end
        chk("lat1_valid_delay", v0, 3);
        chk("lat3_valid_delay", v1, 5);
        chk("first_data", g_dut[0].out_data_w, 32'h0);
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk("handshake_clear", 32'(g_dut[0].out_valid_w), 32'd0);
        wait_read(n);
        chk("poll_period", 7 + n, 11);
        repeat (3) @(negedge clk);
        chk("unchanged_no_valid", 32'(g_dut[0].out_valid_w), 32'd0);

        // Change detection.
        in_port = 32'hDEAD_BEEF;
        wait_read(n);
        repeat (3) @(negedge clk);
        chk("change_valid", 32'(g_dut[0].out_valid_w), 32'd1);
        chk("change_data",  g_dut[0].out_data_w, 32'hDEAD_BEEF);
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk("change_consumed", 32'(g_dut[0].out_valid_w), 32'd0);

        // Waitrequest held for 5 REQ cycles.
        in_port = 32'h1234_5678;
        wr = 1;
        wait_read(n);
        hi = 1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 5) wr = 0;
            hi += int'(g_dut[0].avm_read_w);
        end
        chk("wr_read_cycles", hi, 6);
        chk("wr_address", 32'(g_dut[0].addr_w), 32'd0);
        chk("wr_data", g_dut[0].out_data_w, 32'h1234_5678);

        // Overrun.
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        in_port = 32'h1;
        wait_read(n);
        repeat (3) @(negedge clk);
        chk("ovr_data1", g_dut[0].out_data_w, 32'h1);
        chk("ovr_none",  32'(g_dut[0].overrun_w), 32'd0);
        in_port = 32'h2;
        wait_read(n);
        repeat (3) @(negedge clk);
        chk("ovr_data2", g_dut[0].out_data_w, 32'h2);
        chk("ovr_set",   32'(g_dut[0].overrun_w), 32'd1);
        overrun_clr = 1;
        @(negedge clk);
        overrun_clr = 0;
        chk("ovr_cleared", 32'(g_dut[0].overrun_w), 32'd0);
        in_port = 32'h3;
        wait_read(n);
        repeat (2) @(negedge clk);
        overrun_clr = 1;
        @(negedge clk);
        overrun_clr = 0;
        chk("ovr_set_wins", 32'(g_dut[0].overrun_w), 32'd1);
        chk("ovr_data3",    g_dut[0].out_data_w, 32'h3);

        // Enable drop during WAIT.
        out_ready = 1; overrun_clr = 1;
        @(negedge clk);
        out_ready = 0; overrun_clr = 0;
        in_port = 32'h4;
        wait_read(n);
        @(negedge clk);
        enable = 0;
        hi = 0;
        repeat (30) begin
            @(negedge clk);
            hi += int'(g_dut[0].avm_read_w);
        end
        chk("disabled_no_read", hi, 0);
        chk("disabled_cmp_valid", 32'(g_dut[0].out_valid_w), 32'd1);
        chk("disabled_cmp_data",  g_dut[0].out_data_w, 32'h4);
        enable = 1;
        wait_read(n);
        chk("reenable_delay", n, 8);

        // Reset while stalled in REQ; the unchanged value is reported again.
        repeat (4) @(negedge clk);
        wr = 1;
        wait_read(n);
        reset = 1;
        @(negedge clk);
        chk("midrst_read",  32'(g_dut[0].avm_read_w),  32'd0);
        chk("midrst_valid", 32'(g_dut[0].out_valid_w), 32'd0);
        reset = 0; wr = 0;
        wait_read(n);
        chk("midrst_poll_delay", n, 8);
        repeat (3) @(negedge clk);
        chk("midrst_first_valid", 32'(g_dut[0].out_valid_w), 32'd1);
        chk("midrst_first_data",  g_dut[0].out_data_w, 32'h4);

        // Randomized phase.
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            reset       = ($urandom_range(0, 999) == 0);
            enable      = ($urandom_range(0, 9) != 0);
            wr          = ($urandom_range(0, 2) == 0);
            out_ready   = 1'($urandom_range(0, 1));
            overrun_clr = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 1) in_port = 32'($urandom_range(0, 3));
                else                           in_port = $urandom;
            end
        end
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
